regfile_sb: RTL and testbench

//  Parametrised 2-read/1-write register file with a per-register pending (scoreboard) bit.

---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_sb_dec.sv | 18 +
 rtl/regfile_sb.sv | 83 ++++++++
 tb/tb_regfile_sb.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and index/data types for the scoreboarded register file.
package regfile_pkg;

  localparam int unsigned REGFILE_DATA_W = 16;
  localparam int unsigned REGFILE_NREGS  = 8;
  localparam int unsigned REGFILE_AW     = $clog2(REGFILE_NREGS);

  typedef logic [REGFILE_AW-1:0]     reg_idx_t;
  typedef logic [REGFILE_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_sb_dec.sv
// Binary index to one-hot vector decoder with a global enable.
module dec_onehot #(
  parameter int unsigned N_IN  = 3,
  parameter int unsigned N_OUT = 8
) (
  input  logic             en_i,
  input  logic [N_IN-1:0]  idx_i,
  output logic [N_OUT-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int unsigned i = 0; i < N_OUT; i++) begin
      if (en_i && (idx_i == N_IN'(i))) onehot_o[i] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// 2-read/1-write register file with per-register pending bits, write bypass
// and hazard reporting for operand fetch.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = REGFILE_DATA_W,
  parameter int unsigned NREGS    = REGFILE_NREGS,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          ZERO_REG = 1'b0,
  localparam int unsigned AW      = $clog2(NREGS),
  localparam int unsigned CW      = $clog2(NREGS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  output logic              rd_busy_a,
  input  logic [AW-1:0]     rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_busy_b,
  input  logic              claim_en,
  input  logic [AW-1:0]     claim_addr,
  output logic              claim_ok,
  input  logic              flush,
  output logic [CW-1:0]     pend_cnt
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [NREGS-1:0]  pend_q, pend_d;
  logic [NREGS-1:0]  wr_vec, set_vec;
  logic              wr_eff, claim_set, hit_a, hit_b;

  // With ZERO_REG, R0 is never written or marked, so its flop stays at reset 0
  assign wr_eff    = wr_en & ~(ZERO_REG && (wr_addr == '0));
  assign claim_ok  = claim_en & ~flush &
                     (~pend_q[claim_addr] | (wr_en & (wr_addr == claim_addr)));
  assign claim_set = claim_ok & ~(ZERO_REG && (claim_addr == '0));

  dec_onehot #(.N_IN(AW), .N_OUT(NREGS)) u_dec_wr (
    .en_i     (wr_eff),
    .idx_i    (wr_addr),
    .onehot_o (wr_vec)
  );

  dec_onehot #(.N_IN(AW), .N_OUT(NREGS)) u_dec_claim (
    .en_i     (claim_set),
    .idx_i    (claim_addr),
    .onehot_o (set_vec)
  );

  // A claim newer than a same-cycle write wins; flush never coincides with a set
  assign pend_d = (pend_q & ~wr_vec & {NREGS{~flush}}) | set_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
      pend_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        if (wr_vec[i]) regs_q[i] <= wr_data;
      end
      pend_q <= pend_d;
    end
  end

  always_comb begin
    hit_a     = BYPASS && wr_eff && (wr_addr == rd_addr_a);
    hit_b     = BYPASS && wr_eff && (wr_addr == rd_addr_b);
    rd_data_a = hit_a ? wr_data : regs_q[rd_addr_a];
    rd_data_b = hit_b ? wr_data : regs_q[rd_addr_b];
    rd_busy_a = pend_q[rd_addr_a] & ~hit_a;
    rd_busy_b = pend_q[rd_addr_b] & ~hit_b;
  end

  always_comb begin
    pend_cnt = '0;
    for (int unsigned i = 0; i < NREGS; i++) pend_cnt = pend_cnt + CW'(pend_q[i]);
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench: three instances (default, no bypass, zero register) share stimulus.
module tb_regfile_sb;
  import regfile_pkg::*;

  localparam int S_DA = 0, S_BA = 1, S_DB = 2, S_BB = 3, S_OK = 4, S_PC = 5;
  localparam int D_M = 0, D_NB = 1, D_ZR = 2;

  typedef struct {
    int    cyc;
    string name;
    int    dut;
    int    sig;
    int    val;
  } exp_t;

  logic     clk = 1'b0;
  logic     rst_n;
  logic     wr_en, claim_en, flush;
  reg_idx_t wr_addr, rd_addr_a, rd_addr_b, claim_addr;
  reg_data_t wr_data;

  logic [2:0][15:0] rda, rdb;
  logic [2:0]       rba, rbb, cok;
  logic [2:0][3:0]  pc;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t q[$];
  exp_t e_m;
  int   act_m;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  regfile_sb u_main (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(rda[0]), .rd_busy_a(rba[0]),
    .rd_addr_b(rd_addr_b), .rd_data_b(rdb[0]), .rd_busy_b(rbb[0]),
    .claim_en(claim_en), .claim_addr(claim_addr), .claim_ok(cok[0]),
    .flush(flush), .pend_cnt(pc[0])
  );

  regfile_sb #(.BYPASS(1'b0)) u_nb (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(rda[1]), .rd_busy_a(rba[1]),
    .rd_addr_b(rd_addr_b), .rd_data_b(rdb[1]), .rd_busy_b(rbb[1]),
    .claim_en(claim_en), .claim_addr(claim_addr), .claim_ok(cok[1]),
    .flush(flush), .pend_cnt(pc[1])
  );

  regfile_sb #(.ZERO_REG(1'b1)) u_zr (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(rda[2]), .rd_busy_a(rba[2]),
    .rd_addr_b(rd_addr_b), .rd_data_b(rdb[2]), .rd_busy_b(rbb[2]),
    .claim_en(claim_en), .claim_addr(claim_addr), .claim_ok(cok[2]),
    .flush(flush), .pend_cnt(pc[2])
  );

  function automatic int actual(int d, int s);
    case (s)
      S_DA:    return int'(rda[d]);
      S_BA:    return int'(rba[d]);
      S_DB:    return int'(rdb[d]);
      S_BB:    return int'(rbb[d]);
      S_OK:    return int'(cok[d]);
      default: return int'(pc[d]);
    endcase
  endfunction

  // Monitor: checks every expectation tagged for the current cycle, away from the edge
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e_m   = q.pop_front();
      act_m = actual(e_m.dut, e_m.sig);
      total++;
      if (e_m.cyc != cyc || act_m != e_m.val) begin
        bad++;
        $display("FAIL %s: dut%0d sig%0d got %0h want %0h", e_m.name, e_m.dut, e_m.sig,
                 act_m, e_m.val);
      end
    end
  end

  task automatic ex(string name, int d, int s, int v);
    exp_t e;
    e.cyc = cyc; e.name = name; e.dut = d; e.sig = s; e.val = v;
    q.push_back(e);
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
    wr_en = 1'b0; claim_en = 1'b0; flush = 1'b0;
  endtask

  task automatic wr(int a, int d);
    wr_en = 1'b1; wr_addr = reg_idx_t'(a); wr_data = reg_data_t'(d);
  endtask

  task automatic clm(int a);
    claim_en = 1'b1; claim_addr = reg_idx_t'(a);
  endtask

  task automatic rd(int a, int b);
    rd_addr_a = reg_idx_t'(a); rd_addr_b = reg_idx_t'(b);
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; claim_en = 1'b0; flush = 1'b0;
    wr_addr = '0; wr_data = '0; claim_addr = '0; rd_addr_a = '0; rd_addr_b = '0;

    // Reset state
    next_cycle; rd(3, 5);
    ex("rst_da", D_M, S_DA, 0); ex("rst_pc", D_M, S_PC, 0);
    next_cycle; rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      next_cycle; rd(i, 7 - i);
      ex("init_da", D_M, S_DA, 0); ex("init_ba", D_M, S_BA, 0);
      ex("init_db", D_M, S_DB, 0); ex("init_bb", D_M, S_BB, 0);
      ex("init_pc", D_M, S_PC, 0);
    end

    // Write with same-cycle read
    next_cycle; wr(3, 16'hBEEF); rd(3, 0);
    ex("byp_da", D_M, S_DA, 16'hBEEF); ex("nobyp_da", D_NB, S_DA, 0);
    ex("zr_byp_da", D_ZR, S_DA, 16'hBEEF);
    next_cycle; rd(3, 0);
    ex("wr_da", D_M, S_DA, 16'hBEEF); ex("nb_wr_da", D_NB, S_DA, 16'hBEEF);

    // Claim, refused re-claim, retire
    next_cycle; clm(5); rd(0, 5);
    ex("clm5_ok", D_M, S_OK, 1); ex("clm5_pc", D_M, S_PC, 0); ex("clm5_bb", D_M, S_BB, 0);
    next_cycle; clm(5); rd(0, 5);
    ex("waw_ok", D_M, S_OK, 0); ex("waw_pc", D_M, S_PC, 1); ex("waw_bb", D_M, S_BB, 1);
    next_cycle; wr(5, 16'h0042); rd(0, 5);
    ex("ret_bb", D_M, S_BB, 0); ex("ret_db", D_M, S_DB, 16'h0042);
    ex("ret_pc", D_M, S_PC, 1); ex("nb_ret_bb", D_NB, S_BB, 1);
    next_cycle; rd(0, 5);
    ex("post_pc", D_M, S_PC, 0); ex("post_bb", D_M, S_BB, 0); ex("post_db", D_M, S_DB, 16'h0042);

    // Write and claim same register same cycle
    next_cycle; clm(6);
    ex("clm6_ok", D_M, S_OK, 1);
    next_cycle; clm(6); wr(6, 16'h1234); rd(0, 6);
    ex("wc_ok", D_M, S_OK, 1); ex("wc_pc", D_M, S_PC, 1); ex("wc_bb", D_M, S_BB, 0);
    ex("wc_db", D_M, S_DB, 16'h1234);
    next_cycle; rd(0, 6);
    ex("wc2_db", D_M, S_DB, 16'h1234); ex("wc2_bb", D_M, S_BB, 1); ex("wc2_pc", D_M, S_PC, 1);

    // Flush with write and claim in the same cycle
    next_cycle; clm(1); ex("c1_ok", D_M, S_OK, 1); ex("c1_pc", D_M, S_PC, 1);
    next_cycle; clm(2); ex("c2_ok", D_M, S_OK, 1); ex("c2_pc", D_M, S_PC, 2);
    next_cycle; clm(7); ex("c7_ok", D_M, S_OK, 1); ex("c7_pc", D_M, S_PC, 3);
    next_cycle; flush = 1'b1; wr(4, 16'h00FF); clm(0); rd(7, 4);
    ex("fl_ok", D_M, S_OK, 0); ex("fl_pc", D_M, S_PC, 4); ex("fl_ba", D_M, S_BA, 1);
    ex("fl_db", D_M, S_DB, 16'h00FF);
    next_cycle; rd(4, 6);
    ex("fl2_pc", D_M, S_PC, 0); ex("fl2_da", D_M, S_DA, 16'h00FF);
    ex("fl2_db", D_M, S_DB, 16'h1234); ex("fl2_bb", D_M, S_BB, 0);

    // Fill every pending bit
    for (int i = 0; i < 8; i++) begin
      next_cycle; clm(i);
      ex("fill_ok", D_M, S_OK, 1); ex("fill_pc", D_M, S_PC, i);
    end
    next_cycle; flush = 1'b1;
    ex("full_pc", D_M, S_PC, 8); ex("zr_full_pc", D_ZR, S_PC, 7);

    // Zero register behaviour
    next_cycle; wr(0, 16'hFFFF); rd(0, 0);
    ex("zr_w_da", D_ZR, S_DA, 0); ex("m_w0_da", D_M, S_DA, 16'hFFFF);
    ex("empty_pc", D_M, S_PC, 0);
    next_cycle; clm(0); rd(0, 0);
    ex("zr_c_ok", D_ZR, S_OK, 1); ex("zr_c_da", D_ZR, S_DA, 0);
    ex("m_c0_da", D_M, S_DA, 16'hFFFF);
    next_cycle; rd(0, 0);
    ex("zr_ba", D_ZR, S_BA, 0); ex("zr_pc", D_ZR, S_PC, 0);
    ex("m_r0_ba", D_M, S_BA, 1); ex("m_r0_pc", D_M, S_PC, 1);

    // Asynchronous reset during a write burst
    next_cycle; wr(1, 16'h1111);
    next_cycle; wr(2, 16'h2222); rd(1, 0);
    ex("burst_da", D_M, S_DA, 16'h1111);
    next_cycle; wr(3, 16'h3333); rd(1, 6); rst_n = 1'b0;
    ex("arst_da", D_M, S_DA, 0); ex("arst_db", D_M, S_DB, 0);
    ex("arst_pc", D_M, S_PC, 0); ex("arst_ba", D_M, S_BA, 0);
    ex("zr_arst_da", D_ZR, S_DA, 0);
    next_cycle; rst_n = 1'b1; wr(3, 16'h3333); rd(2, 0);
    ex("rel_da", D_M, S_DA, 0);
    next_cycle; rd(3, 0);
    ex("rel_wr_da", D_M, S_DA, 16'h3333); ex("nb_rel_wr_da", D_NB, S_DA, 16'h3333);

    next_cycle;
    next_cycle;
    if (q.size() > 0) begin
      $display("FAIL drain: pending=%0d want 0", q.size());
      bad += q.size();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
